// File: rtl/riscv_du_trig_pkg.sv
// Shared types for the debug-unit trigger bank: compare-source and match enums,
// the CTRL register layout and the register map offsets.
package riscv_du_trig_pkg;

   typedef enum logic [2:0] {
      CC_OFF   = 3'd0,
      CC_FETCH = 3'd1,
      CC_LOAD  = 3'd2,
      CC_STORE = 3'd3,
      CC_LDST  = 3'd4,
      CC_SDATA = 3'd5
   } cc_e;

   typedef enum logic [1:0] {
      MT_EQ   = 2'd0,
      MT_GE   = 2'd1,
      MT_LT   = 2'd2,
      MT_MASK = 2'd3
   } match_e;

   typedef struct packed {
      logic [15:0] reload;
      logic [8:0]  rsvd;
      logic        chain;
      match_e      match;
      cc_e         cc;
      logic        en;
   } ctrl_t;

   localparam int unsigned HIT_OFS     = 'h00;
   localparam int unsigned TRIG_BASE   = 'h10;
   localparam int unsigned TRIG_STRIDE = 4;

   localparam int unsigned REG_CTRL = 0;
   localparam int unsigned REG_DATA = 1;
   localparam int unsigned REG_MASK = 2;
   localparam int unsigned REG_CNT  = 3;

   function automatic int unsigned trig_ofs(input int unsigned n, input int unsigned k);
      return TRIG_BASE + TRIG_STRIDE * n + k;
   endfunction

endpackage

// File: rtl/riscv_du_trig_cmp.sv
// One trigger: CTRL/DATA/MASK/CNT registers, comparator and hit-count prescaler.
// Store-data compare (cc=5) exists only when RISCV_DU_TRIG_DVAL_EN is defined.
module riscv_du_trig_cmp
   import riscv_du_trig_pkg::*;
#(
   parameter int XLEN = 32
)(
   input  logic            clk,
   input  logic            rstn,
   input  logic            ctrl_wr,
   input  logic            data_wr,
   input  logic            mask_wr,
   input  logic            cnt_wr,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] if_pc,
   input  logic            if_valid,
   input  logic            flush,
   input  logic [XLEN-1:0] mem_adr,
   input  logic            mem_valid,
   input  logic            mem_we,
   input  logic [XLEN-1:0] mem_wdata,
   input  logic            chain_in,
   output logic            raw_match,
   output logic            fire,
   output ctrl_t           ctrl,
   output logic [XLEN-1:0] data,
   output logic [XLEN-1:0] mask,
   output logic [15:0]     cnt
);

   logic [XLEN-1:0] x;
   logic            qual;
   logic            cmp_ok;
   logic            counted;

   always_comb begin
      x    = mem_adr;
      qual = 1'b0;
      case (ctrl.cc)
         CC_FETCH: begin
            x    = if_pc;
            qual = if_valid & ~flush;
         end
         CC_LOAD:  qual = mem_valid & ~mem_we;
         CC_STORE: qual = mem_valid & mem_we;
         CC_LDST:  qual = mem_valid;
`ifdef RISCV_DU_TRIG_DVAL_EN
         CC_SDATA: begin
            x    = mem_wdata;
            qual = mem_valid & mem_we;
         end
`endif
         default:  qual = 1'b0;
      endcase
   end

   always_comb begin
      cmp_ok = 1'b0;
      case (ctrl.match)
         MT_EQ:   cmp_ok = (x == data);
         MT_GE:   cmp_ok = (x >= data);
         MT_LT:   cmp_ok = (x < data);
         default: cmp_ok = ((x & mask) == (data & mask));
      endcase
   end

   // Chain qualifies against the neighbour's raw match, not its fire, so a
   // prescaled predecessor still arms this trigger on every hit.
   assign raw_match = ctrl.en & qual & cmp_ok;
   assign counted   = raw_match & (~ctrl.chain | chain_in);
   assign fire      = counted & (cnt == 16'd0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ctrl <= '0;
         data <= '0;
         mask <= '0;
         cnt  <= '0;
      end else begin
         if (ctrl_wr) ctrl <= ctrl_t'(wdata[31:0]);
         if (data_wr) data <= wdata;
         if (mask_wr) mask <= wdata;
         if (ctrl_wr)
            cnt <= wdata[31:16];
         else if (cnt_wr)
            cnt <= wdata[15:0];
         else if (counted)
            cnt <= (cnt == 16'd0) ? ctrl.reload : cnt - 16'd1;
      end
   end

   logic unused_bits;
`ifdef RISCV_DU_TRIG_DVAL_EN
   assign unused_bits = ^ctrl.rsvd;
`else
   assign unused_bits = ^{ctrl.rsvd, mem_wdata};
`endif

endmodule

// File: rtl/riscv_du_trigger.sv
// Debug-unit trigger bank: register decode/readback, sticky HIT register and halt-request FSM.
// reg_ack/reg_rdata one cycle after the strobe; brk_req rises the cycle after a fire.
module riscv_du_trigger
   import riscv_du_trig_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int NUM_TRIG = 4,
   parameter int ADDR_W   = 8
)(
   input  logic                clk,
   input  logic                rstn,
   input  logic                reg_strb,
   input  logic                reg_we,
   input  logic [ADDR_W-1:0]   reg_addr,
   input  logic [XLEN-1:0]     reg_wdata,
   output logic [XLEN-1:0]     reg_rdata,
   output logic                reg_ack,
   input  logic [XLEN-1:0]     if_pc,
   input  logic                if_valid,
   input  logic                flush,
   input  logic [XLEN-1:0]     mem_adr,
   input  logic                mem_valid,
   input  logic                mem_we,
   input  logic [XLEN-1:0]     mem_wdata,
   input  logic                core_halted,
   output logic                brk_req,
   output logic [NUM_TRIG-1:0] trig_hit
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_REQ    = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   logic                           acc;
   logic                           wr;
   logic                           hit_sel;
   logic [NUM_TRIG-1:0]            raw;
   logic [NUM_TRIG-1:0]            fire;
   logic [NUM_TRIG-1:0]            hit;
   logic [NUM_TRIG-1:0]            w1c;
   logic [NUM_TRIG-1:0][XLEN-1:0]  trig_rd;
   logic [XLEN-1:0]                rd_mux;
   logic [1:0]                     state;
   logic [1:0]                     state_nxt;

   assign acc     = reg_strb & ~reg_ack;
   assign wr      = acc & reg_we;
   assign hit_sel = (reg_addr == ADDR_W'(HIT_OFS));

   for (genvar n = 0; n < NUM_TRIG; n++) begin : g_trig
      localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(trig_ofs(n, REG_CTRL));
      localparam logic [ADDR_W-1:0] A_DATA = ADDR_W'(trig_ofs(n, REG_DATA));
      localparam logic [ADDR_W-1:0] A_MASK = ADDR_W'(trig_ofs(n, REG_MASK));
      localparam logic [ADDR_W-1:0] A_CNT  = ADDR_W'(trig_ofs(n, REG_CNT));

      logic            sel_ctrl, sel_data, sel_mask, sel_cnt;
      logic            chain_in;
      ctrl_t           ctrl;
      logic [XLEN-1:0] data;
      logic [XLEN-1:0] mask;
      logic [15:0]     cnt;

      assign sel_ctrl = (reg_addr == A_CTRL);
      assign sel_data = (reg_addr == A_DATA);
      assign sel_mask = (reg_addr == A_MASK);
      assign sel_cnt  = (reg_addr == A_CNT);

      if (n == 0) begin : g_head
         assign chain_in = 1'b1;
      end else begin : g_link
         assign chain_in = raw[n-1];
      end

      riscv_du_trig_cmp #(.XLEN(XLEN)) u_cmp (
         .clk       (clk),
         .rstn      (rstn),
         .ctrl_wr   (wr & sel_ctrl),
         .data_wr   (wr & sel_data),
         .mask_wr   (wr & sel_mask),
         .cnt_wr    (wr & sel_cnt),
         .wdata     (reg_wdata),
         .if_pc     (if_pc),
         .if_valid  (if_valid),
         .flush     (flush),
         .mem_adr   (mem_adr),
         .mem_valid (mem_valid),
         .mem_we    (mem_we),
         .mem_wdata (mem_wdata),
         .chain_in  (chain_in),
         .raw_match (raw[n]),
         .fire      (fire[n]),
         .ctrl      (ctrl),
         .data      (data),
         .mask      (mask),
         .cnt       (cnt)
      );

      assign trig_rd[n] = sel_ctrl ? XLEN'(ctrl) :
                          sel_data ? data :
                          sel_mask ? mask :
                          sel_cnt  ? XLEN'(cnt) : '0;
   end

   // Register windows are disjoint, so at most one term is non-zero.
   always_comb begin
      rd_mux = hit_sel ? XLEN'(hit) : '0;
      for (int i = 0; i < NUM_TRIG; i++) rd_mux = rd_mux | trig_rd[i];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         reg_ack   <= 1'b0;
         reg_rdata <= '0;
      end else begin
         reg_ack   <= acc;
         reg_rdata <= acc ? rd_mux : '0;
      end
   end

   // A new fire beats a same-cycle W1C of the same bit.
   assign w1c = (wr & hit_sel) ? reg_wdata[NUM_TRIG-1:0] : '0;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) hit <= '0;
      else       hit <= (hit & ~w1c) | fire;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (|fire) state_nxt = ST_REQ;
         ST_REQ:    if (core_halted) state_nxt = ST_HALTED;
         ST_HALTED: if (!core_halted) state_nxt = (|fire) ? ST_REQ : ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   assign brk_req  = (state == ST_REQ);
   assign trig_hit = hit;

endmodule

// File: tb/tb_riscv_du_trigger.sv
// Bench for riscv_du_trigger: directed scenarios then randomized traffic against a behavioural model.
module tb_riscv_du_trigger;

   localparam int XLEN     = 32;
   localparam int NUM_TRIG = 4;
   localparam int ADDR_W   = 8;

   logic                clk = 1'b0;
   logic                rstn;
   logic                reg_strb, reg_we;
   logic [ADDR_W-1:0]   reg_addr;
   logic [XLEN-1:0]     reg_wdata, reg_rdata;
   logic                reg_ack;
   logic [XLEN-1:0]     if_pc, mem_adr, mem_wdata;
   logic                if_valid, flush, mem_valid, mem_we, core_halted;
   logic                brk_req;
   logic [NUM_TRIG-1:0] trig_hit;

   always #5 clk = ~clk;

   riscv_du_trigger #(.XLEN(XLEN), .NUM_TRIG(NUM_TRIG), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rstn(rstn),
      .reg_strb(reg_strb), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_rdata(reg_rdata), .reg_ack(reg_ack),
      .if_pc(if_pc), .if_valid(if_valid), .flush(flush),
      .mem_adr(mem_adr), .mem_valid(mem_valid), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .core_halted(core_halted), .brk_req(brk_req), .trig_hit(trig_hit)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Behavioural model state
   typedef enum {M_IDLE, M_REQ, M_HALTED} mstate_e;
   logic [31:0]         m_ctrl [NUM_TRIG];
   logic [31:0]         m_data [NUM_TRIG];
   logic [31:0]         m_mask [NUM_TRIG];
   logic [15:0]         m_cnt  [NUM_TRIG];
   logic [NUM_TRIG-1:0] m_hit;
   mstate_e             m_state;
   bit                  m_ack;
   logic [31:0]         m_rdata;

   task automatic m_reset();
      for (int n = 0; n < NUM_TRIG; n++) begin
         m_ctrl[n] = 0; m_data[n] = 0; m_mask[n] = 0; m_cnt[n] = 0;
      end
      m_hit = 0; m_state = M_IDLE; m_ack = 0; m_rdata = 0;
   endtask

   function automatic bit m_raw(input int n);
      logic [31:0] x;
      bit ok, cmp;
      int cc;
      x = 0; ok = 0; cmp = 0;
      cc = int'(m_ctrl[n][3:1]);
      if (!m_ctrl[n][0]) return 0;
      case (cc)
         1: begin ok = if_valid && !flush;     x = if_pc;   end
         2: begin ok = mem_valid && !mem_we;   x = mem_adr; end
         3: begin ok = mem_valid && mem_we;    x = mem_adr; end
         4: begin ok = mem_valid;              x = mem_adr; end
`ifdef RISCV_DU_TRIG_DVAL_EN
         5: begin ok = mem_valid && mem_we;    x = mem_wdata; end
`endif
         default: ok = 0;
      endcase
      case (int'(m_ctrl[n][5:4]))
         0: cmp = (x == m_data[n]);
         1: cmp = (x >= m_data[n]);
         2: cmp = (x <  m_data[n]);
         default: cmp = ((x & m_mask[n]) == (m_data[n] & m_mask[n]));
      endcase
      return ok && cmp;
   endfunction

   function automatic logic [31:0] m_read(input logic [ADDR_W-1:0] a);
      int ai, n;
      ai = int'(a);
      if (ai == 0) return 32'(m_hit);
      if (ai >= 16 && ai < 16 + 4 * NUM_TRIG) begin
         n = (ai - 16) / 4;
         case ((ai - 16) % 4)
            0: return m_ctrl[n];
            1: return m_data[n];
            2: return m_mask[n];
            default: return 32'(m_cnt[n]);
         endcase
      end
      return 0;
   endfunction

   // One clock: model consumes the current inputs, DUT clocks, outputs compared after the edge.
   task automatic step();
      bit raw [NUM_TRIG];
      bit q [NUM_TRIG];
      logic [NUM_TRIG-1:0] fv, w1c;
      bit acc;
      logic [31:0] rd;
      int ai, n;
      for (int i = 0; i < NUM_TRIG; i++) raw[i] = m_raw(i);
      fv = 0;
      for (int i = 0; i < NUM_TRIG; i++) begin
         q[i] = raw[i] && (i == 0 || !m_ctrl[i][6] || raw[i-1]);
         fv[i] = q[i] && (m_cnt[i] == 0);
      end
      acc = reg_strb && !m_ack;
      rd  = m_read(reg_addr);
      for (int i = 0; i < NUM_TRIG; i++)
         if (q[i]) m_cnt[i] = (m_cnt[i] == 0) ? m_ctrl[i][31:16] : m_cnt[i] - 16'd1;
      w1c = (acc && reg_we && reg_addr == 0) ? reg_wdata[NUM_TRIG-1:0] : '0;
      if (acc && reg_we) begin
         ai = int'(reg_addr);
         if (ai >= 16 && ai < 16 + 4 * NUM_TRIG) begin
            n = (ai - 16) / 4;
            case ((ai - 16) % 4)
               0: begin m_ctrl[n] = reg_wdata; m_cnt[n] = reg_wdata[31:16]; end
               1: m_data[n] = reg_wdata;
               2: m_mask[n] = reg_wdata;
               default: m_cnt[n] = reg_wdata[15:0];
            endcase
         end
      end
      m_hit = (m_hit & ~w1c) | fv;
      case (m_state)
         M_IDLE:   if (fv != 0) m_state = M_REQ;
         M_REQ:    if (core_halted) m_state = M_HALTED;
         default:  if (!core_halted) m_state = (fv != 0) ? M_REQ : M_IDLE;
      endcase
      m_ack   = acc;
      m_rdata = acc ? rd : 32'd0;
      @(posedge clk);
      #1;
      check_val("ack", reg_ack, m_ack);
      if (m_ack) check_val("rdata", reg_rdata, m_rdata);
      check_val("brk", brk_req, m_state == M_REQ);
      check_val("hit", trig_hit, m_hit);
   endtask

   task automatic bus(input bit we, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                      output logic [31:0] v);
      reg_strb = 1; reg_we = we; reg_addr = a; reg_wdata = d;
      step();
      v = reg_rdata;
      reg_strb = 0; reg_we = 0;
      step();
   endtask

   task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      logic [31:0] v;
      bus(1'b1, a, d, v);
   endtask

   task automatic rd(input logic [ADDR_W-1:0] a, output logic [31:0] v);
      bus(1'b0, a, 32'd0, v);
   endtask

   task automatic idle_inputs();
      if_pc = 0; if_valid = 0; flush = 0;
      mem_adr = 0; mem_valid = 0; mem_we = 0; mem_wdata = 0;
   endtask

   task automatic release_halt();
      core_halted = 1; step();
      core_halted = 0; step();
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 4))
         0: return 32'h0000_0100;
         1: return 32'h0000_2004;
         2: return 32'h8000_0ABC;
         3: return 32'hDEAD_BEEF;
         default: return $urandom();
      endcase
   endfunction

   task automatic rand_inputs();
      if_pc = pick(); if_valid = 1'($urandom_range(0, 1)); flush = ($urandom_range(0, 7) == 0);
      mem_adr = pick(); mem_valid = 1'($urandom_range(0, 1)); mem_we = 1'($urandom_range(0, 1));
      mem_wdata = pick();
      if ($urandom_range(0, 15) == 0) core_halted = ~core_halted;
   endtask

   logic [31:0] v;
   logic [31:0] d;
   logic [ADDR_W-1:0] a;
   int r;

   initial begin
      rstn = 0; reg_strb = 0; reg_we = 0; reg_addr = 0; reg_wdata = 0; core_halted = 0;
      idle_inputs();
      m_reset();
      #1;
      check_val("rst_brk", brk_req, 0);
      check_val("rst_hit", trig_hit, 0);
      check_val("rst_ack", reg_ack, 0);
      check_val("rst_rdata", reg_rdata, 0);
      @(posedge clk); @(posedge clk); #1;
      rstn = 1;

      // Fetch EQ trigger
      wr(8'h10, 32'h0000_0003);
      wr(8'h11, 32'h0000_0100);
      if_pc = 32'h100; if_valid = 1; step(); if_valid = 0;
      check_val("t1_hit", trig_hit, 32'h1);
      check_val("t1_brk", brk_req, 1);
      release_halt();
      check_val("t1_idle", brk_req, 0);
      wr(8'h00, 32'hF);

      // Prescaled load GE trigger
      wr(8'h14, 32'h0002_0015);
      wr(8'h15, 32'h0000_2000);
      mem_adr = 32'h2004; mem_we = 0;
      for (int i = 0; i < 3; i++) begin
         mem_valid = 1; step(); mem_valid = 0; step();
         check_val($sformatf("t2_load%0d", i), trig_hit[1], (i == 2));
      end
      rd(8'h17, v);
      check_val("t2_cnt", v, 32'd2);
      release_halt();
      wr(8'h00, 32'hF);

      // Masked, chained trigger
      wr(8'h15, 32'hFFFF_0000);
      wr(8'h18, 32'h0000_0075);
      wr(8'h19, 32'h8000_0000);
      wr(8'h1A, 32'hFFFF_F000);
      mem_adr = 32'h8000_0ABC; mem_valid = 1; step(); mem_valid = 0;
      check_val("t3_nochain", trig_hit[2], 0);
      wr(8'h15, 32'h8000_0000);
      mem_valid = 1; step(); mem_valid = 0;
      check_val("t3_chain", trig_hit[2], 1);
      release_halt();
      wr(8'h00, 32'hF);
      idle_inputs();

      // W1C racing a fire, halt handshake
      if_pc = 32'h100; if_valid = 1; step();
      wr(8'h00, 32'h1);
      if_valid = 0;
      check_val("t4_w1c_race", trig_hit[0], 1);
      wr(8'h00, 32'h1);
      check_val("t4_w1c", trig_hit[0], 0);
      core_halted = 1; step();
      check_val("t4_halted", brk_req, 0);
      core_halted = 0; if_valid = 1; step(); if_valid = 0;
      check_val("t4_rereq", brk_req, 1);
      release_halt(); step();
      check_val("t4_idle", brk_req, 0);
      wr(8'h00, 32'hF);

      // Store-data compare
      wr(8'h1C, 32'h0000_000B);
      wr(8'h1D, 32'hDEAD_BEEF);
      mem_adr = 32'h40; mem_wdata = 32'hDEAD_BEEF; mem_we = 1; mem_valid = 1; step();
      mem_valid = 0; mem_we = 0;
`ifdef RISCV_DU_TRIG_DVAL_EN
      check_val("t5_dval", trig_hit[3], 1);
`else
      check_val("t5_dval", trig_hit[3], 0);
`endif
      rd(8'h1C, v);
      check_val("t5_ctrl_rb", v, 32'hB);
      release_halt();
      wr(8'h00, 32'hF);

      // Unmapped read, reset while requesting
      rd(8'h08, v);
      check_val("t6_unmapped", v, 0);
      if_pc = 32'h100; if_valid = 1; step(); if_valid = 0;
      check_val("t6_req", brk_req, 1);
      #2 rstn = 0;
      #1;
      check_val("t6_rst_brk", brk_req, 0);
      check_val("t6_rst_hit", trig_hit, 0);
      m_reset();
      @(posedge clk); #1;
      rstn = 1;
      rd(8'h10, v);
      check_val("t6_rst_ctrl", v, 0);

      // Randomized traffic
      for (int it = 0; it < 1500; it++) begin
         rand_inputs();
         r = $urandom_range(0, 99);
         if (r < 15) begin
            case ($urandom_range(0, 5))
               0: begin a = 8'h00; d = $urandom(); end
               1: begin
                  a = 8'(16 + 4 * $urandom_range(0, NUM_TRIG - 1));
                  d = {16'($urandom_range(0, 2)), 9'($urandom()), 1'($urandom()),
                       2'($urandom()), 3'($urandom_range(0, 5)), ($urandom_range(0, 7) != 0)};
               end
               2: begin a = 8'(17 + 4 * $urandom_range(0, NUM_TRIG - 1)); d = pick(); end
               3: begin
                  a = 8'(18 + 4 * $urandom_range(0, NUM_TRIG - 1));
                  d = ($urandom_range(0, 1) != 0) ? 32'hFFFF_F000 : $urandom();
               end
               4: begin a = 8'(19 + 4 * $urandom_range(0, NUM_TRIG - 1)); d = 32'($urandom_range(0, 3)); end
               default: begin a = 8'($urandom_range(0, 63)); d = $urandom(); end
            endcase
            wr(a, d);
         end else if (r < 25) begin
            rd(8'($urandom_range(0, 63)), v);
         end else begin
            step();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
